// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD/SUB/AND/OR/SLT/SLL/SRL) complete on the accept edge.
// MUL runs an iterative shift-add over WIDTH cycles and stalls the input.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. While
// out_valid is high, ALUResult and the flags hold steady until out_ready.
module alu_multicycle #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOperation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             IllegalOp,
    output logic             state_dbg
);

    localparam logic [3:0] OP_ADD = 4'b1001;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_SLT = 4'b1110;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               state;
    logic [SHW:0]         cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_carry;
    logic                 sc_ovf;
    logic                 sc_ill;
    logic                 accept;

    assign state_dbg = state;

    // Input is blocked during a multiply and whenever the output slot is
    // occupied and not being drained this cycle; no dependency on in_valid.
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath and flags, plus the next shift-add accumulator.
    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        diff     = {1'b0, A} - {1'b0, B};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        case (ALUOperation)
            OP_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = diff[WIDTH-1:0];
                sc_carry = diff[WIDTH];
                sc_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: sc_res = A << B[SHW-1:0];
            OP_SRL: sc_res = A >> B[SHW-1:0];
            OP_MUL: sc_res = '0;
            default: sc_ill = 1'b1;
        endcase
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM, multiply iteration and the registered output slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            IllegalOp <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (ALUOperation == OP_MUL) begin
                            mcand     <= {{WIDTH{1'b0}}, A};
                            mplier    <= B;
                            acc       <= '0;
                            cnt       <= (SHW+1)'(WIDTH);
                            out_valid <= 1'b0;
                            state     <= S_MUL;
                        end else begin
                            ALUResult <= sc_res;
                            Zero      <= (sc_res == '0);
                            Negative  <= sc_res[WIDTH-1];
                            Carry     <= sc_carry;
                            Overflow  <= sc_ovf;
                            IllegalOp <= sc_ill;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    // Last step: the low half is the result, high half flags overflow.
                    if (cnt == (SHW+1)'(1)) begin
                        ALUResult <= acc_next[WIDTH-1:0];
                        Zero      <= (acc_next[WIDTH-1:0] == '0);
                        Negative  <= acc_next[WIDTH-1];
                        Carry     <= 1'b0;
                        Overflow  <= |acc_next[2*WIDTH-1:WIDTH];
                        IllegalOp <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle (WIDTH=32) with hand-computed vectors.
module tb_alu_multicycle;

    localparam int W = 32;

    localparam logic [3:0] OP_ADD = 4'b1001;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_SLT = 4'b1110;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0010;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         illegal_op;
    logic         state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    alu_multicycle #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (a),
        .B            (b),
        .ALUOperation (op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ALUResult    (alu_result),
        .Zero         (zero),
        .Negative     (negative),
        .Carry        (carry),
        .Overflow     (overflow),
        .IllegalOp    (illegal_op),
        .state_dbg    (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checkers
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare ALUResult with the oldest expected result.
    task automatic chk_result(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=0x%08h expected=<empty queue>", tag, alu_result);
        end else begin
            e = exp_q.pop_front();
            chk(tag, alu_result, e);
        end
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic n,
                             input logic c, input logic v, input logic il);
        chkb({tag, "_zero"}, zero, z);
        chkb({tag, "_neg"},  negative, n);
        chkb({tag, "_carry"}, carry, c);
        chkb({tag, "_ovf"},  overflow, v);
        chkb({tag, "_ill"},  illegal_op, il);
    endtask

    // Drivers: present one request, expect it to be accepted on the next edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp_res);
        op = o; a = x; b = y; in_valid = 1'b1;
        #1;
        chkb("in_ready_before_issue", in_ready, 1'b1);
        exp_q.push_back(exp_res);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; also records whether in_ready ever rose.
    task automatic wait_valid(output int cycles, output logic ready_seen);
        cycles = 0;
        ready_seen = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    int   cyc;
    logic rdy_seen;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chkb("rst_out_valid", out_valid, 1'b0);
        chk ("rst_result", alu_result, 32'h0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_state", state_dbg, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD wrap-around
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0);
        chkb("add_valid", out_valid, 1'b1);
        chk_result("add_result");
        chk_flags("add", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // SUB signed overflow
        issue(OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF);
        chk_result("sub_result");
        chk_flags("sub", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // SUB borrow
        issue(OP_SUB, 32'h3, 32'h5, 32'hFFFF_FFFE);
        chk_result("sub_borrow_result");
        chk_flags("sub_borrow", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // SLT signed: -1 < 0
        issue(OP_SLT, 32'hFFFF_FFFF, 32'h0, 32'h1);
        chk_result("slt_result");
        chk_flags("slt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // MUL with high-half overflow
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0);
        chkb("mul1_valid_cleared", out_valid, 1'b0);
        chkb("mul1_state", state_dbg, 1'b1);
        wait_valid(cyc, rdy_seen);
        chk ("mul1_latency", cyc, 32'd32);
        chkb("mul1_in_ready_low", rdy_seen, 1'b0);
        chk_result("mul1_result");
        chk_flags("mul1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // MUL 7x6; inputs are scrambled and a request is held during the multiply
        issue(OP_MUL, 32'd7, 32'd6, 32'd42);
        a = $urandom; b = $urandom; op = OP_ADD; in_valid = 1'b1;
        wait_valid(cyc, rdy_seen);
        in_valid = 1'b0;
        chk ("mul2_latency", cyc, 32'd32);
        chkb("mul2_in_ready_low", rdy_seen, 1'b0);
        chk_result("mul2_result");
        chk_flags("mul2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure: ADD 3+4 held while a pending OR waits
        issue(OP_ADD, 32'd3, 32'd4, 32'd7);
        out_ready = 1'b0;
        op = OP_OR; a = 32'h0000_00F0; b = 32'h0000_000F; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chkb("bp_valid_held", out_valid, 1'b1);
            chkb("bp_in_ready_low", in_ready, 1'b0);
            chk ("bp_result_stable", alu_result, 32'd7);
        end
        chk_result("bp_add_result");
        out_ready = 1'b1;
        #1;
        chkb("bp_in_ready_release", in_ready, 1'b1);
        exp_q.push_back(32'h0000_00FF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chkb("bp_or_valid", out_valid, 1'b1);
        chk_result("bp_or_result");
        @(posedge clk); #1;
        chkb("bp_drained", out_valid, 1'b0);

        // Reset during MUL on its 10th cycle
        issue(OP_MUL, 32'd3, 32'd5, 32'd15);
        void'(exp_q.pop_back());
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chkb("mulrst_valid", out_valid, 1'b0);
        chkb("mulrst_in_ready", in_ready, 1'b1);
        chk ("mulrst_result", alu_result, 32'h0);
        chkb("mulrst_state", state_dbg, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chkb("mulrst_no_partial", out_valid, 1'b0);
        issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        chk_result("and_result");
        chk_flags("and", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal opcode, then legal ops clear IllegalOp
        issue(4'b0000, 32'h1234_5678, 32'h9, 32'h0);
        chk_result("ill_result");
        chk_flags("ill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(OP_SLL, 32'h1, 32'd31, 32'h8000_0000);
        chk_result("sll_result");
        chk_flags("sll", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(OP_SRL, 32'h8000_0000, 32'h21, 32'h4000_0000);
        chk_result("srl_result");
        chk_flags("srl", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
